// File: rtl/prog_updown_counter.sv
// rtl/prog_updown_counter.sv - programmable up/down counter with binary or modulus wrap
// Optional build macro: PROG_UPDOWN_COUNTER_SAT_EN (terminal steps saturate instead of wrapping)
module prog_updown_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             incr,
  input  logic             mode,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             small_mod;
  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] load_next;
  logic             at_term;
  logic             step;
  logic [WIDTH-1:0] step_next;

  // Top of the mode-0 range; modulus 0 and 1 both collapse to a range of just 0.
  always_comb begin
    small_mod = (modulus <= ONE);
    mod_m1    = small_mod ? ZERO : (modulus - ONE);
  end

  // Parallel-load value, clamped into range when counting against a modulus.
  always_comb begin
    load_next = load_val;
    if (!mode && (load_val > mod_m1)) begin
      load_next = mod_m1;
    end
  end

  // Terminal detection for the current direction, mode and modulus.
  always_comb begin
    at_term = 1'b0;
    if (mode) begin
      at_term = incr ? (count == ONES) : (count == ZERO);
    end else if (small_mod) begin
      at_term = 1'b1;
    end else begin
      at_term = incr ? (count >= mod_m1) : (count == ZERO);
    end
  end

  // An enabled step that is not overridden by clear or load.
  always_comb begin
    step = enable & ~clear & ~load;
    tc   = rst_n & step & at_term;
  end

  // Value taken by an enabled step.
  always_comb begin
    step_next = count;
    if (mode) begin
      if (incr) begin
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
        step_next = at_term ? ONES : (count + ONE);
`else
        step_next = count + ONE;
`endif
      end else begin
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
        step_next = at_term ? ZERO : (count - ONE);
`else
        step_next = count - ONE;
`endif
      end
    end else if (small_mod) begin
      step_next = ZERO;
    end else if (incr) begin
      if (at_term) begin
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
        step_next = mod_m1;
`else
        step_next = ZERO;
`endif
      end else begin
        step_next = count + ONE;
      end
    end else begin
      if (count == ZERO) begin
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
        step_next = ZERO;
`else
        step_next = mod_m1;
`endif
      end else if (count > mod_m1) begin
        // Out-of-range count after a modulus change resyncs to the top without flagging a wrap.
        step_next = mod_m1;
      end else begin
        step_next = count - ONE;
      end
    end
  end

  // Count register with clear > load > enable > hold priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= ZERO;
    end else if (clear) begin
      count <= ZERO;
    end else if (load) begin
      count <= load_next;
    end else if (enable) begin
      count <= step_next;
    end
  end

  // One-cycle pulse following any enabled terminal step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= step & at_term;
    end
  end

endmodule

// File: tb/tb_prog_updown_counter.sv
// tb/tb_prog_updown_counter.sv - directed self-checking bench for prog_updown_counter
module tb_prog_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       enable;
  logic       incr;
  logic       mode;
  logic [7:0] modulus;
  logic [7:0] count;
  logic       tc;
  logic       wrapped;

  int total;
  int bad;

  prog_updown_counter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .incr(incr), .mode(mode), .modulus(modulus),
    .count(count), .tc(tc), .wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; load = 0; enable = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; load = 0; load_val = 8'd0; enable = 1; incr = 0; mode = 1; modulus = 8'd0;
    #1;
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", tc); end
    @(negedge clk);
    rst_n = 1; enable = 0;
    tick();
  endtask

  task automatic test_binary_up_wrap();
    idle(); mode = 1; incr = 1; load = 1; load_val = 8'hFE;
    tick();
    total++; if (count !== 8'hFE) begin bad++; $display("FAIL bin_load got=%h exp=fe", count); end
    load = 0; enable = 1; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL bin_tc_fe got=%b exp=0", tc); end
    tick();
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL bin_ff got=%h exp=ff", count); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL bin_tc_ff got=%b exp=1", tc); end
    tick();
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL bin_wrap got=%h exp=ff", count); end
`else
    total++; if (count !== 8'h00) begin bad++; $display("FAIL bin_wrap got=%h exp=00", count); end
`endif
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL bin_wrapped got=%b exp=1", wrapped); end
    enable = 0;
    tick();
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL bin_wrapped_clr got=%b exp=0", wrapped); end
  endtask

  task automatic test_binary_down();
    idle(); mode = 1; incr = 0; clear = 1;
    tick();
    clear = 0; enable = 1; #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL bdn_tc got=%b exp=1", tc); end
    tick();
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
    total++; if (count !== 8'h00) begin bad++; $display("FAIL bdn_wrap got=%h exp=00", count); end
`else
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL bdn_wrap got=%h exp=ff", count); end
`endif
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL bdn_wrapped got=%b exp=1", wrapped); end
  endtask

  task automatic test_hold();
    idle(); mode = 1; load = 1; load_val = 8'd33;
    tick();
    load = 0;
    tick();
    tick();
    total++; if (count !== 8'd33) begin bad++; $display("FAIL hold_count got=%0d exp=33", count); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL hold_wrapped got=%b exp=0", wrapped); end
  endtask

  task automatic test_mod_down();
    idle(); clear = 1;
    tick();
    clear = 0; mode = 0; modulus = 8'd10; incr = 0; enable = 1; #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL mdn_tc got=%b exp=1", tc); end
    tick();
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
    total++; if (count !== 8'd0) begin bad++; $display("FAIL mdn_count got=%0d exp=0", count); end
`else
    total++; if (count !== 8'd9) begin bad++; $display("FAIL mdn_count got=%0d exp=9", count); end
`endif
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL mdn_wrapped got=%b exp=1", wrapped); end
`ifndef PROG_UPDOWN_COUNTER_SAT_EN
    tick();
    total++; if (count !== 8'd8) begin bad++; $display("FAIL mdn_next got=%0d exp=8", count); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL mdn_wrapped2 got=%b exp=0", wrapped); end
`endif
  endtask

  task automatic test_mod_up();
    idle(); mode = 0; modulus = 8'd10; incr = 1; load = 1; load_val = 8'd8;
    tick();
    load = 0; enable = 1;
    tick();
    total++; if (count !== 8'd9) begin bad++; $display("FAIL mup_9 got=%0d exp=9", count); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL mup_tc got=%b exp=1", tc); end
    tick();
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
    total++; if (count !== 8'd9) begin bad++; $display("FAIL mup_wrap got=%0d exp=9", count); end
`else
    total++; if (count !== 8'd0) begin bad++; $display("FAIL mup_wrap got=%0d exp=0", count); end
`endif
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL mup_wrapped got=%b exp=1", wrapped); end
  endtask

  task automatic test_load_clamp();
    idle(); mode = 0; modulus = 8'd10; load = 1; load_val = 8'd200;
    tick();
    total++; if (count !== 8'd9) begin bad++; $display("FAIL clamp_count got=%0d exp=9", count); end
    clear = 1; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL clamp_tc got=%b exp=0", tc); end
    tick();
    total++; if (count !== 8'd0) begin bad++; $display("FAIL clear_prio got=%0d exp=0", count); end
    clear = 0; modulus = 8'd0; load_val = 8'd5;
    tick();
    total++; if (count !== 8'd0) begin bad++; $display("FAIL load_mod0 got=%0d exp=0", count); end
  endtask

  task automatic test_resync();
    idle(); mode = 1; load = 1; load_val = 8'd50;
    tick();
    load = 0; mode = 0; modulus = 8'd20; incr = 0; enable = 1; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL rs_tc got=%b exp=0", tc); end
    tick();
    total++; if (count !== 8'd19) begin bad++; $display("FAIL rs_down got=%0d exp=19", count); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL rs_down_wr got=%b exp=0", wrapped); end
    idle(); mode = 1; load = 1; load_val = 8'd50;
    tick();
    load = 0; mode = 0; incr = 1; enable = 1; #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL rs_up_tc got=%b exp=1", tc); end
    tick();
`ifdef PROG_UPDOWN_COUNTER_SAT_EN
    total++; if (count !== 8'd19) begin bad++; $display("FAIL rs_up got=%0d exp=19", count); end
`else
    total++; if (count !== 8'd0) begin bad++; $display("FAIL rs_up got=%0d exp=0", count); end
`endif
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL rs_up_wr got=%b exp=1", wrapped); end
  endtask

  task automatic test_mod1();
    idle(); clear = 1;
    tick();
    clear = 0; mode = 0; modulus = 8'd1; incr = 1; enable = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (tc !== 1'b1) begin bad++; $display("FAIL m1_tc[%0d] got=%b exp=1", i, tc); end
      tick();
      total++; if (count !== 8'd0) begin bad++; $display("FAIL m1_count[%0d] got=%0d exp=0", i, count); end
      total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL m1_wr[%0d] got=%b exp=1", i, wrapped); end
    end
  endtask

  task automatic test_async_reset();
    idle(); mode = 1; load = 1; load_val = 8'd255;
    tick();
    load = 0; incr = 1; enable = 1;
    tick();
    load = 1; load_val = 8'd7; enable = 0;
    tick();
    total++; if (count !== 8'd7) begin bad++; $display("FAIL ar_pre got=%0d exp=7", count); end
    load = 0; enable = 1; incr = 0;
    #2; rst_n = 0; #1;
    total++; if (count !== 8'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL ar_wrapped got=%b exp=0", wrapped); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL ar_tc got=%b exp=0", tc); end
    @(negedge clk);
    rst_n = 1; incr = 1;
    tick();
    total++; if (count !== 8'd1) begin bad++; $display("FAIL ar_resume got=%0d exp=1", count); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_binary_up_wrap();
    test_binary_down();
    test_hold();
    test_mod_down();
    test_mod_up();
    test_load_clamp();
    test_resync();
    test_mod1();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_updown_counter.md
PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 Parameter: WIDTH, 8, counter width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: clear  input  1  synchronous clear of count.
REQ-005 Port: load  input  1  synchronous parallel load.
REQ-006 Port: load_val  input  WIDTH  value loaded when load=1.
REQ-007 Port: enable  input  1  count-enable; count advances one step per cycle when 1.
REQ-008 Port: incr  input  1  direction; 1 = up, 0 = down.
REQ-009 Port: mode  input  1  1 = full binary (modulus 2^WIDTH); 0 = programmable modulus.
REQ-010 Port: modulus  input  WIDTH  mode-0 modulus; count range 0..modulus-1.
REQ-011 Port: count  output  WIDTH  registered counter value.
REQ-012 Port: tc  output  1  combinational terminal count, for cascading.
REQ-013 Port: wrapped  output  1  registered one-cycle pulse, high the cycle after a wrap or saturation event.

Function
REQ-014 Control priority SHALL be clear > load > enable > hold.
REQ-015 clear=1: count <= 0, wrapped <= 0, irrespective of load/enable.
REQ-016 load=1, clear=0: count <= load_val in mode 1; in mode 0 count <= min(load_val, modulus-1); modulus<=1 loads 0; wrapped <= 0.
REQ-017 enable=0, clear=0, load=0: count holds, wrapped <= 0.
REQ-018 Mode 1 up: count <= count+1 modulo 2^WIDTH; terminal value 2^WIDTH-1.
REQ-019 Mode 1 down: count <= count-1 modulo 2^WIDTH; terminal value 0.
REQ-020 Mode 0 up: count >= modulus-1 -> 0 (terminal); else count+1.
REQ-021 Mode 0 down: count == 0 -> modulus-1 (terminal); count > modulus-1 -> modulus-1 (non-terminal resync); else count-1.
REQ-022 Mode 0 with modulus 0 or 1: enabled step forces count to 0; every enabled step is terminal.
REQ-023 tc = enable & ~clear & ~load & (count at terminal value for current incr/mode/modulus); zero latency.
REQ-024 wrapped <= 1 for exactly one cycle after any enabled terminal step; else 0.
REQ-025 mode, incr, modulus may change on any cycle; the new values take effect on the same edge, no pipeline.
REQ-026 Arithmetic in WIDTH bits; modulus-1 computed without underflow (modulus 0 handled per REQ-022).

Reset
REQ-027 rst_n=0 SHALL asynchronously force count=0, wrapped=0, independent of clk.
REQ-028 Reset deassertion mid-operation: first rising edge after rst_n=1 applies normal REQ-014 priority from count=0.
REQ-029 tc SHALL read 0 while rst_n=0.

Configuration
REQ-030 Macro PROG_UPDOWN_COUNTER_SAT_EN: defined -> terminal steps saturate (up holds at terminal value, down holds at 0); tc and wrapped still assert per REQ-023/024; undefined -> wrap per REQ-018..022.

Verification
REQ-031 WIDTH=8, mode=1, incr=1, enable=1 from 8'hFE -> FF (tc=1) -> 00, wrapped=1 one cycle after.
REQ-032 mode=0, modulus=10, incr=0, count=0, enable=1 -> count=9, tc=1 in prior cycle, wrapped pulse; with SAT_EN count stays 0.
REQ-033 mode=0, modulus=10, load=1, load_val=200 -> count=9; same cycle clear=1 -> count=0.
REQ-034 count=50, mode=0, modulus set to 20, incr=0, enable=1 -> count=19, wrapped=0; incr=1 instead -> count=0, wrapped=1.
REQ-035 mode=0, modulus=1, enable=1 for 3 cycles -> count=0 throughout, tc=1 each cycle, wrapped=1 each following cycle.
REQ-036 rst_n pulsed low between edges at count=7 -> count=0, wrapped=0 immediately; resumes counting from 0 on next enabled edge.
